mmio_slot_initiator: RTL and testbench
======================================

Name: mmio_slot_initiator

Overview:
Initiator side of the MMIO slot interface. It accepts one read or write request from the MMIO subsystem over a valid/ready handshake, then drives chip_select, read/write, addr and wr_data to a slot responder (uart, timer, and so on). It waits for the responder's wr_done or rd_done, captures the read data and error flags, and releases the slot with a one-cycle transaction_completed pulse. The captured response is returned upstream, held until the upstream side accepts it. A watchdog terminates any access the responder never completes.

Parameters:
ADDR_WIDTH, 8, slot register address width
DATA_WIDTH, 32, slot data width
TIMEOUT_CYCLES, 64, max cycles in ACCESS before abort; must be >= 4
TIMEOUT_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
req_valid  in  1  upstream request valid
req_ready  out  1  module can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  slot register address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  response available
resp_ready  in  1  upstream consumes response
resp_rdata  out  DATA_WIDTH  read data (0 for writes, aborted accesses, and error reads)
resp_slave_error  out  1  responder flagged an illegal access
resp_decode_error  out  1  responder flagged an unmapped address
resp_timeout  out  1  watchdog expired
chip_select  out  1  slot select
read  out  1  slot read strobe (level)
write  out  1  slot write strobe (level)
addr  out  ADDR_WIDTH  slot address
wr_data  out  DATA_WIDTH  slot write data
transaction_completed  out  1  one-cycle release pulse to responder
rd_data  in  DATA_WIDTH  responder read data, valid with rd_done
wr_done  in  1  responder write-complete pulse
rd_done  in  1  responder read-complete pulse
slave_error  in  1  responder error, valid only with done
decode_error  in  1  responder error, valid only with done

Behaviour:
- Reset: arst_n is the asynchronous, active-low reset; clk is the clock.
  - All state returns to IDLE.
  - All outputs are 0 except req_ready=1.
  - The request/response registers and the watchdog counter are cleared.
  - Reset mid-access abandons the transaction with no response; the responder shares arst_n.
- FSM states are IDLE, ACCESS, RELEASE, RESP. All slot outputs are driven from registers (no comb path from req_* to slot pins).
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_write/addr/wdata, clear the watchdog, go to ACCESS.
- ACCESS:
  - chip_select=1; read=~req_write_q; write=req_write_q; addr and wr_data are held stable for the whole state.
  - done = req_write_q ? wr_done : rd_done; the opposite done input is ignored.
  - On done: capture rd_data (reads only; writes store 0), slave_error and decode_error; timeout=0; go to RELEASE.
  - Otherwise the watchdog increments. When count==TIMEOUT_CYCLES-1 and no done: timeout=1, rdata=0, errors=0, go to RELEASE.
  - done and expiry in the same cycle: done wins.
  - slave_error and decode_error are sampled only with done (the responder resets them to 1).
- RELEASE:
  - Exactly one cycle.
  - chip_select, read and write are 0; transaction_completed=1.
  - The pulse is issued on the timeout path too, so a late responder returns to idle.
  - Go to RESP.
- RESP:
  - resp_valid=1, with resp_* stable until resp_valid&&resp_ready.
  - On handshake, go to IDLE.
  - req_ready=0 in every state except IDLE, giving single-outstanding operation.
- Latency with a zero-wait responder (done two cycles after chip_select rises): accept in cycle 0, chip_select in cycles 1-3, done sampled in cycle 3, transaction_completed in cycle 4, resp_valid from cycle 5.
- Back-to-back: earliest next chip_select is 2 cycles after the resp handshake (IDLE one cycle, then ACCESS). This guarantees the responder sees select low after its release.
- A stray wr_done or rd_done in IDLE, RELEASE or RESP is ignored.

Decomposition:
- mmio_pkg holds:
  - slot_state_e enum (IDLE, ACCESS, RELEASE, RESP).
  - slot_resp_t struct: rdata, slave_error, decode_error, timeout.
  - MMIO_ADDR_WIDTH and MMIO_DATA_WIDTH constants shared with the responders.
- One sub-module: slot_watchdog (clear, enable, count, expired at TIMEOUT_CYCLES-1).

Test Plan:
1. Write 0x41 to addr 0x04 on a uart responder (dvsr set first) -> exactly one slot write; resp_valid at cycle 5; errors=0; timeout=0; rdata=0; one-cycle transaction_completed.
2. Write 0x145 to addr 0x08, then read 0x08 -> resp_rdata=0x00000145; no errors; chip_select low for at least 1 cycle between accesses.
3. Read addr 0x20 -> resp_decode_error=1; resp_slave_error=0; resp_rdata=0. Then write addr 0x10 -> resp_slave_error=1.
4. Stub responder never asserts done, TIMEOUT_CYCLES=16 -> ACCESS lasts exactly 16 cycles; resp_timeout=1; transaction_completed pulsed once. A done forced in the last ACCESS cycle gives timeout=0.
5. Hold resp_ready=0 for 10 cycles after resp_valid -> resp_* stable; req_ready=0; a new req_valid is ignored until the handshake.
6. Assert arst_n low in the second ACCESS cycle -> chip_select, read, write, resp_valid all 0 immediately; req_ready=1 after release; the next request completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and widths for the MMIO slot interface, used by the initiator
// and by the slot responders.
package mmio_pkg;

  localparam int MMIO_ADDR_WIDTH = 8;
  localparam int MMIO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE,
    RESP
  } slot_state_e;

  typedef struct packed {
    logic [MMIO_DATA_WIDTH-1:0] rdata;
    logic                       slave_error;
    logic                       decode_error;
    logic                       timeout;
  } slot_resp_t;

endpackage

// File: rtl/slot_watchdog.sv
// Access watchdog: counts cycles while enabled and flags expiry on the last
// permitted cycle, so the owner can abort in that same cycle.
module slot_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_WIDTH-1:0] count;

  // Saturates at the expiry value; the owner leaves ACCESS on expiry anyway.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  assign expired = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mmio_slot_initiator.sv
// Initiator side of the MMIO slot interface: one outstanding request, slot pins
// driven from registers, response held until upstream accepts it.
module mmio_slot_initiator
  import mmio_pkg::*;
#(
  parameter int ADDR_WIDTH     = MMIO_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MMIO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_slave_error,
  output logic                  resp_decode_error,
  output logic                  resp_timeout,
  output logic                  chip_select,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  transaction_completed,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_done,
  input  logic                  rd_done,
  input  logic                  slave_error,
  input  logic                  decode_error
);

  slot_state_e state;
  slot_resp_t  resp_q;
  logic        req_write_q;
  logic        slot_done;
  logic        expired;

  // Only the done matching the access direction counts.
  assign slot_done = req_write_q ? wr_done : rd_done;

  slot_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .arst_n (arst_n),
    .clear  (state == IDLE),
    .enable (state == ACCESS),
    .expired(expired)
  );

  // Slot pins and response are all registered; done beats a same-cycle expiry.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state                 <= IDLE;
      req_ready             <= 1'b1;
      req_write_q           <= 1'b0;
      addr                  <= '0;
      wr_data               <= '0;
      chip_select           <= 1'b0;
      read                  <= 1'b0;
      write                 <= 1'b0;
      transaction_completed <= 1'b0;
      resp_valid            <= 1'b0;
      resp_q                <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_write_q <= req_write;
            addr        <= req_addr;
            wr_data     <= req_wdata;
            chip_select <= 1'b1;
            read        <= ~req_write;
            write       <= req_write;
            req_ready   <= 1'b0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (slot_done || expired) begin
            chip_select           <= 1'b0;
            read                  <= 1'b0;
            write                 <= 1'b0;
            transaction_completed <= 1'b1;
            state                 <= RELEASE;
            if (slot_done) begin
              resp_q.rdata        <= (req_write_q || slave_error || decode_error) ? '0 : rd_data;
              resp_q.slave_error  <= slave_error;
              resp_q.decode_error <= decode_error;
              resp_q.timeout      <= 1'b0;
            end else begin
              resp_q <= '{rdata: '0, slave_error: 1'b0, decode_error: 1'b0, timeout: 1'b1};
            end
          end
        end
        RELEASE: begin
          transaction_completed <= 1'b0;
          resp_valid            <= 1'b1;
          state                 <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_rdata        = resp_q.rdata;
  assign resp_slave_error  = resp_q.slave_error;
  assign resp_decode_error = resp_q.decode_error;
  assign resp_timeout      = resp_q.timeout;

endmodule

// File: tb/tb_mmio_slot_initiator.sv
// Directed and randomized bench for mmio_slot_initiator with a behavioural
// slot responder and a transaction-level reference model.
module tb_mmio_slot_initiator;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_slave_error, resp_decode_error, resp_timeout;
  logic          chip_select, read, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          transaction_completed;
  logic [DW-1:0] rd_data;
  logic          wr_done, rd_done, slave_error, decode_error;

  int checks = 0;
  int errors = 0;

  // Responder state and knobs
  int            rsp_lat = 2;
  bit            rsp_noise = 1'b0;
  int            rsp_cnt = 0;
  bit            rsp_answered = 1'b0;
  logic          rsp_wr = 1'b0, rsp_rd = 1'b0;
  logic          rsp_serr = 1'b1, rsp_derr = 1'b1;
  logic [DW-1:0] rsp_rdata = '0;
  logic [DW-1:0] rsp_mem [16];
  logic          stray_wr = 1'b0, stray_rd = 1'b0;
  logic [DW-1:0] ref_mem [16];

  assign wr_done      = rsp_wr | stray_wr;
  assign rd_done      = rsp_rd | stray_rd;
  assign slave_error  = rsp_serr;
  assign decode_error = rsp_derr;
  assign rd_data      = rsp_rdata;

  always #5 clk = ~clk;

  mmio_slot_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_slave_error(resp_slave_error), .resp_decode_error(resp_decode_error),
    .resp_timeout(resp_timeout),
    .chip_select(chip_select), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .transaction_completed(transaction_completed),
    .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done),
    .slave_error(slave_error), .decode_error(decode_error)
  );

  // Responder: done after rsp_lat select cycles; errors idle high, data idle random.
  always @(negedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_cnt = 0; rsp_answered = 1'b0; rsp_wr = 1'b0; rsp_rd = 1'b0;
      rsp_serr = 1'b1; rsp_derr = 1'b1;
      for (int i = 0; i < 16; i++) rsp_mem[i] = '0;
    end else begin
      rsp_wr = 1'b0; rsp_rd = 1'b0; rsp_serr = 1'b1; rsp_derr = 1'b1;
      rsp_rdata = $urandom;
      if (transaction_completed) begin
        rsp_cnt = 0; rsp_answered = 1'b0;
      end else if (chip_select && !rsp_answered) begin
        rsp_cnt++;
        if (rsp_cnt > rsp_lat) begin
          rsp_answered = 1'b1;
          if (write) rsp_wr = 1'b1; else rsp_rd = 1'b1;
          rsp_derr = (addr >= 8'h20);
          rsp_serr = !rsp_derr && write && (addr >= 8'h10);
          if (!rsp_derr && !rsp_serr) begin
            if (write) rsp_mem[addr[3:0]] = wr_data;
            else if (addr < 8'h10) rsp_rdata = rsp_mem[addr[3:0]];
            else rsp_rdata = 32'hC0DE_0000 | {24'h0, addr};
          end
        end else if (rsp_noise && rsp_cnt == 1) begin
          if (write) rsp_rd = 1'b1; else rsp_wr = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation from the register map and access timing.
  task automatic refModel(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int lat, output logic [DW-1:0] e_rdata, output logic e_serr,
                          output logic e_derr, output logic e_to, output int e_access);
    e_to = (lat >= TO);
    e_access = e_to ? TO : lat + 1;
    e_rdata = '0; e_serr = 1'b0; e_derr = 1'b0;
    if (!e_to) begin
      if (a >= 8'h20) e_derr = 1'b1;
      else if (a >= 8'h10) begin
        if (w) e_serr = 1'b1; else e_rdata = 32'hC0DE_0000 + DW'(a);
      end else if (w) ref_mem[a[3:0]] = wd;
      else e_rdata = ref_mem[a[3:0]];
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the handshake.
  task automatic applyStimulus(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input int lat, input int hold, input bit noise);
    logic [DW-1:0] e_rdata;
    logic e_serr, e_derr, e_to;
    int e_access, c, cs_n, tc_n, wr_n, rd_n, seen;
    bit addr_ok;
    refModel(w, a, wd, lat, e_rdata, e_serr, e_derr, e_to, e_access);
    rsp_lat = lat; rsp_noise = noise;
    checkOutput("idle_req_ready", req_ready, 1);
    checkOutput("idle_cs_low", chip_select, 0);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    c = 0; cs_n = 0; tc_n = 0; wr_n = 0; rd_n = 0; seen = -1; addr_ok = 1'b1;
    while (seen < 0 && c < 100) begin
      @(negedge clk); c++;
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
      if (chip_select) begin
        cs_n++;
        if (write) wr_n++;
        if (read) rd_n++;
        if (addr !== a || (w && wr_data !== wd)) addr_ok = 1'b0;
      end
      if (transaction_completed) tc_n++;
      if (resp_valid) seen = c;
    end
    checkOutput("resp_latency", seen, e_access + 2);
    checkOutput("cs_cycles", cs_n, e_access);
    checkOutput("strobe_cycles", w ? wr_n : rd_n, e_access);
    checkOutput("wrong_strobe", w ? rd_n : wr_n, 0);
    checkOutput("tc_pulses", tc_n, 1);
    checkOutput("slot_addr_data_stable", addr_ok, 1);
    for (int i = 0; i <= hold; i++) begin
      checkOutput("resp_valid", resp_valid, 1);
      checkOutput("resp_rdata", resp_rdata, e_rdata);
      checkOutput("resp_slave_error", resp_slave_error, e_serr);
      checkOutput("resp_decode_error", resp_decode_error, e_derr);
      checkOutput("resp_timeout", resp_timeout, e_to);
      checkOutput("busy_req_ready", req_ready, 0);
      checkOutput("resp_cs_low", chip_select, 0);
      if (i == hold) begin
        req_valid = 1'b0; resp_ready = 1'b1;
      end else begin
        req_valid = 1'b1; resp_ready = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checkOutput("resp_valid_dropped", resp_valid, 0);
    checkOutput("ready_after_handshake", req_ready, 1);
  endtask

  initial begin
    #1 arst_n = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_cs", chip_select, 0);
    checkOutput("rst_rw", {read, write}, 0);
    checkOutput("rst_tc", transaction_completed, 0);
    checkOutput("rst_resp", {resp_rdata, resp_slave_error, resp_decode_error, resp_timeout}, 0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    $display("[TB] uart-style writes");
    applyStimulus(1'b1, 8'h00, 32'h0000_0036, 2, 0, 1'b0);
    applyStimulus(1'b1, 8'h04, 32'h0000_0041, 2, 0, 1'b0);

    $display("[TB] write then read back");
    applyStimulus(1'b1, 8'h08, 32'h0000_0145, 2, 0, 1'b0);
    applyStimulus(1'b0, 8'h08, 32'h0, 2, 0, 1'b1);

    $display("[TB] error responses");
    applyStimulus(1'b0, 8'h20, 32'h0, 2, 0, 1'b0);
    applyStimulus(1'b1, 8'h10, 32'hDEAD_BEEF, 3, 0, 1'b1);

    $display("[TB] watchdog");
    applyStimulus(1'b1, 8'h0C, 32'h1234_5678, 1000, 0, 1'b0);
    applyStimulus(1'b0, 8'h0C, 32'h0, TO - 1, 0, 1'b0);
    applyStimulus(1'b0, 8'h04, 32'h0, TO, 0, 1'b0);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 8'h04, 32'h0, 4, 10, 1'b0);

    $display("[TB] stray done in idle");
    stray_wr = 1'b1; stray_rd = 1'b1;
    @(negedge clk);
    stray_wr = 1'b0; stray_rd = 1'b0;
    checkOutput("stray_cs", chip_select, 0);
    checkOutput("stray_tc", transaction_completed, 0);
    checkOutput("stray_resp_valid", resp_valid, 0);

    $display("[TB] reset mid-access");
    rsp_lat = 2;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h04; req_wdata = 32'h55;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_cs", chip_select, 1);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cs", chip_select, 0);
    checkOutput("mid_rst_rw", {read, write}, 0);
    checkOutput("mid_rst_resp_valid", resp_valid, 0);
    checkOutput("mid_rst_req_ready", req_ready, 1);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", req_ready, 1);
    applyStimulus(1'b1, 8'h04, 32'h0000_0077, 2, 0, 1'b0);
    applyStimulus(1'b0, 8'h04, 32'h0, 2, 0, 1'b0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] ra;
      int region, lat;
      region = $urandom_range(0, 3);
      ra = (region == 3) ? AW'($urandom_range(8'h20, 8'hFF)) :
           (region == 2) ? AW'($urandom_range(8'h10, 8'h1F)) : AW'($urandom_range(0, 15));
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 6);
      applyStimulus(1'($urandom), ra, $urandom, lat, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
